secuenciador_alu: RTL and testbench
===================================

Name: secuenciador_alu

Overview:
- Registered control stage wrapped around the combinational 8-bit ALU: an upstream producer submits (opcode, A, B) over a valid/ready handshake.
- The block latches and drives the ALU operand inputs, waits a fixed settle time, then captures the 16-bit result and flags.
- It presents the result to a downstream consumer over a second valid/ready handshake.
- It traps division/modulo by zero, where the ALU produces no defined result, and counts completed operations.

Parameters:
- ESPERA_CICLOS, 1: number of cycles operands are held on the ALU before capture; legal range 1..15, 0 illegal.
- ANCHO_CONT, 8: width of Contador_Ops.

Ports:
- Reloj  in  1  clock; all state updates on rising edge.
- Reinicio_n  in  1  reset; one clock; reset is synchronous and active-low.
- Entrada_Valida  in  1  upstream request valid.
- Entrada_Lista  out  1  block can accept a request.
- Codigo_In  in  3  opcode: 000 SUM, 001 RES, 010 PRO, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 XOR.
- A_In  in  8  operand A.
- B_In  in  8  operand B.
- Codigo_OP  out  3  registered opcode driven to ALU.
- Dato0  out  8  registered operand A driven to ALU.
- Dato1  out  8  registered operand B driven to ALU.
- Resultado  in  16  ALU result.
- banderaA  in  1  ALU carry/borrow flag (bit 8).
- Salida_Valida  out  1  result valid.
- Salida_Lista  in  1  downstream ready.
- Resultado_Out  out  16  captured result.
- Acarreo_Out  out  1  captured carry/borrow.
- Cero_Out  out  1  captured result equals zero.
- Error_Div  out  1  DIV/MOD with B==0.
- Contador_Ops  out  ANCHO_CONT  completed operations, wraps.

Behaviour:
- Reset:
  - Any edge with Reinicio_n=0: state REPOSO; all outputs 0, including Entrada_Lista.
  - Wait counter cleared; any in-flight op is discarded and not counted.
- Entrada_Lista is registered: it is 1 exactly when the state is REPOSO, starting with the first edge after Reinicio_n returns high.
- FSM states: REPOSO, EJECUTA, ENTREGA.
- REPOSO:
  - Handshake fires at edge N when Entrada_Valida=1 and Entrada_Lista=1.
  - At that edge: latch Codigo_In/A_In/B_In into Codigo_OP/Dato0/Dato1; load wait counter with ESPERA_CICLOS-1; clear Entrada_Lista; go to EJECUTA.
  - Entrada_Valida with Entrada_Lista=0 is ignored; upstream holds its request.
- EJECUTA:
  - Lasts exactly ESPERA_CICLOS cycles; the counter decrements each edge.
  - At the edge where the counter is 0, capture results and go to ENTREGA with Salida_Valida=1.
  - Latency: Salida_Valida is high after edge N+ESPERA_CICLOS.
- Capture rules:
  - Normal case: Resultado_Out=Resultado; Cero_Out=(Resultado==16'h0000), computed locally; Error_Div=0.
  - Acarreo_Out=banderaA for SUM and RES only, 0 for every other opcode.
  - Zero-divisor case: if Codigo_OP is 011 or 100 and Dato1==0, Resultado_Out=16'h0000, Acarreo_Out=0, Cero_Out=0, Error_Div=1. The ALU inputs are ignored for this op; latency is unchanged.
- ENTREGA:
  - Result outputs and Salida_Valida stay stable while Salida_Lista=0, with no timeout.
  - Edge with Salida_Lista=1: Salida_Valida->0, Contador_Ops+1, state REPOSO, Entrada_Lista->1.
  - Error_Div ops are counted.
- Codigo_OP/Dato0/Dato1 hold their values until the next handshake; they are not cleared on completion.
- Resultado_Out/Acarreo_Out/Cero_Out/Error_Div hold after Salida_Valida falls, until the next capture.
- Contador_Ops wraps from 2^ANCHO_CONT-1 to 0 with no flag.
- Throughput: one op per ESPERA_CICLOS+2 cycles minimum; requests never overlap.

Test Plan:
- Reset: hold Reinicio_n=0 for 3 cycles with Entrada_Valida=1 -> all outputs 0; Entrada_Lista=1 after the first edge with Reinicio_n=1; no op accepted during reset.
- SUM: A=200, B=100, Salida_Lista=1 -> Resultado_Out=16'h012C, Acarreo_Out=1, Cero_Out=0, Salida_Valida high exactly one cycle after handshake (default), Contador_Ops=1.
- RES: 5-5 -> Resultado_Out=0, Cero_Out=1, Acarreo_Out=0. Then RES 3-5 -> Resultado_Out=16'hFFFE, Acarreo_Out=1. Then AND 8'hF0&8'h0F -> 0, Cero_Out=1, Acarreo_Out=0 even if banderaA=1.
- Zero divisor: DIV 7/0 and MOD 0/0 -> Resultado_Out=0, Error_Div=1, Cero_Out=0. Then DIV 7/2 -> Resultado_Out=3, Error_Div=0. Contador_Ops increments all three times.
- Backpressure: PRO 16x16 with Salida_Lista=0 for 5 cycles -> Resultado_Out=16'h0100 stable, Entrada_Lista=0, a new request presented meanwhile is not latched. Raise Salida_Lista -> REPOSO next edge, then the pending request is accepted.
- ESPERA_CICLOS=3: handshake at edge N -> Dato0/Dato1 stable and Salida_Valida=0 through N+2, high after N+3. Reinicio_n=0 at N+2 -> REPOSO, no output, counter unchanged. Separately, 256 completed ops -> Contador_Ops=0.

Source files
------------

// File: rtl/secuenciador_alu.sv
// Registered sequencer around the combinational 8-bit ALU: accepts (opcode, A, B)
// over valid/ready, holds operands for a settle time, then captures and delivers the result.
module secuenciador_alu #(
    parameter int unsigned ESPERA_CICLOS = 1,
    parameter int unsigned ANCHO_CONT    = 8
) (
    input  logic                  Reloj,
    input  logic                  Reinicio_n,
    input  logic                  Entrada_Valida,
    output logic                  Entrada_Lista,
    input  logic [2:0]            Codigo_In,
    input  logic [7:0]            A_In,
    input  logic [7:0]            B_In,
    output logic [2:0]            Codigo_OP,
    output logic [7:0]            Dato0,
    output logic [7:0]            Dato1,
    input  logic [15:0]           Resultado,
    input  logic                  banderaA,
    output logic                  Salida_Valida,
    input  logic                  Salida_Lista,
    output logic [15:0]           Resultado_Out,
    output logic                  Acarreo_Out,
    output logic                  Cero_Out,
    output logic                  Error_Div,
    output logic [ANCHO_CONT-1:0] Contador_Ops
);

    localparam int unsigned ANCHO_ESPERA = 4;
    localparam logic [ANCHO_ESPERA-1:0] CARGA_ESPERA = ANCHO_ESPERA'(ESPERA_CICLOS - 1);

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_RES = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef enum logic [1:0] {
        REPOSO,
        EJECUTA,
        ENTREGA
    } estado_t;

    estado_t                 estado;
    logic [ANCHO_ESPERA-1:0] espera;
    logic                    div_cero_c;
    logic                    acarreo_c;

    // Divide/modulo by zero has no defined ALU result, so it is trapped locally.
    assign div_cero_c = ((Codigo_OP == OP_DIV) || (Codigo_OP == OP_MOD)) && (Dato1 == 8'h00);
    assign acarreo_c  = ((Codigo_OP == OP_SUM) || (Codigo_OP == OP_RES)) && banderaA;

    always_ff @(posedge Reloj) begin
        if (!Reinicio_n) begin
            estado        <= REPOSO;
            espera        <= '0;
            Entrada_Lista <= 1'b0;
            Codigo_OP     <= '0;
            Dato0         <= '0;
            Dato1         <= '0;
            Salida_Valida <= 1'b0;
            Resultado_Out <= '0;
            Acarreo_Out   <= 1'b0;
            Cero_Out      <= 1'b0;
            Error_Div     <= 1'b0;
            Contador_Ops  <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (Entrada_Valida && Entrada_Lista) begin
                        Codigo_OP     <= Codigo_In;
                        Dato0         <= A_In;
                        Dato1         <= B_In;
                        espera        <= CARGA_ESPERA;
                        Entrada_Lista <= 1'b0;
                        estado        <= EJECUTA;
                    end else begin
                        Entrada_Lista <= 1'b1;
                    end
                end
                EJECUTA: begin
                    if (espera == '0) begin
                        if (div_cero_c) begin
                            Resultado_Out <= 16'h0000;
                            Acarreo_Out   <= 1'b0;
                            Cero_Out      <= 1'b0;
                            Error_Div     <= 1'b1;
                        end else begin
                            Resultado_Out <= Resultado;
                            Acarreo_Out   <= acarreo_c;
                            Cero_Out      <= (Resultado == 16'h0000);
                            Error_Div     <= 1'b0;
                        end
                        Salida_Valida <= 1'b1;
                        estado        <= ENTREGA;
                    end else begin
                        espera <= espera - ANCHO_ESPERA'(1);
                    end
                end
                ENTREGA: begin
                    // Results stay put until the consumer takes them; no timeout.
                    if (Salida_Lista) begin
                        Salida_Valida <= 1'b0;
                        Contador_Ops  <= Contador_Ops + ANCHO_CONT'(1);
                        Entrada_Lista <= 1'b1;
                        estado        <= REPOSO;
                    end
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_alu.sv
// Bench for secuenciador_alu: transaction-level timing/result model checked every cycle,
// plus directed vectors with hand-computed results; a second instance covers a 3-cycle settle.
module tb_secuenciador_alu;

    localparam int unsigned ESP = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance with the default settle time
    logic        rst_n, ev, el, sv, sl, acar, cero, errd, band, band_raw, force_c;
    logic [2:0]  cin, cop;
    logic [7:0]  ain, bin, d0, d1, cnt;
    logic [15:0] res, rout;

    // Instance with a 3-cycle settle time
    logic        rst3_n, ev3, el3, sv3, sl3, acar3, cero3, errd3, band3;
    logic [2:0]  cin3, cop3;
    logic [7:0]  ain3, bin3, d0_3, d1_3, cnt3;
    logic [15:0] res3, rout3;

    // Stand-in for the ALU; garbage on divide-by-zero so the trap must ignore it.
    function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        case (op)
            3'd0:    r = 16'(a) + 16'(b);
            3'd1:    r = 16'(a) - 16'(b);
            3'd2:    r = 16'(a) * 16'(b);
            3'd3:    r = (b == 8'h00) ? 16'hFFFF : 16'(a / b);
            3'd4:    r = (b == 8'h00) ? 16'hFFFF : 16'(a % b);
            3'd5:    r = {8'h00, a & b};
            3'd6:    r = {8'h00, a | b};
            default: r = {8'h00, a ^ b};
        endcase
        return {r[8], r};
    endfunction

    assign {band_raw, res} = alu_ref(cop, d0, d1);
    assign band            = band_raw | force_c;
    assign {band3, res3}   = alu_ref(cop3, d0_3, d1_3);

    secuenciador_alu #(.ESPERA_CICLOS(ESP), .ANCHO_CONT(8)) u_dut (
        .Reloj(clk), .Reinicio_n(rst_n), .Entrada_Valida(ev), .Entrada_Lista(el),
        .Codigo_In(cin), .A_In(ain), .B_In(bin), .Codigo_OP(cop), .Dato0(d0), .Dato1(d1),
        .Resultado(res), .banderaA(band), .Salida_Valida(sv), .Salida_Lista(sl),
        .Resultado_Out(rout), .Acarreo_Out(acar), .Cero_Out(cero), .Error_Div(errd),
        .Contador_Ops(cnt)
    );

    secuenciador_alu #(.ESPERA_CICLOS(3), .ANCHO_CONT(8)) u_dut3 (
        .Reloj(clk), .Reinicio_n(rst3_n), .Entrada_Valida(ev3), .Entrada_Lista(el3),
        .Codigo_In(cin3), .A_In(ain3), .B_In(bin3), .Codigo_OP(cop3), .Dato0(d0_3), .Dato1(d1_3),
        .Resultado(res3), .banderaA(band3), .Salida_Valida(sv3), .Salida_Lista(sl3),
        .Resultado_Out(rout3), .Acarreo_Out(acar3), .Cero_Out(cero3), .Error_Div(errd3),
        .Contador_Ops(cnt3)
    );

    // Expected captured outputs {error, zero, carry, result} from the arithmetic rules.
    function automatic logic [18:0] esperado(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int          s;
        logic [15:0] r;
        logic        c, e;
        r = '0; c = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = 16'(s); c = (s > 255); end
            3'd1: begin s = int'(a) - int'(b); r = 16'(s); c = (s < 0); end
            3'd2: begin s = int'(a) * int'(b); r = 16'(s); end
            3'd3: if (b == 8'h00) e = 1'b1; else r = 16'(a / b);
            3'd4: if (b == 8'h00) e = 1'b1; else r = 16'(a % b);
            3'd5: r = {8'h00, a & b};
            3'd6: r = {8'h00, a | b};
            default: r = {8'h00, a ^ b};
        endcase
        return {e, (!e && (r == 16'h0000)), c, r};
    endfunction

    // Transaction model: edge timestamps of acceptance and delivery.
    int          ciclo = 0, t_acc = 0, ops = 0;
    logic        pend = 1'b0, rdy = 1'b0, v_prev;
    logic [2:0]  m_op = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [18:0] cur = '0, nxt = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ciclo = 0; t_acc = 0; ops = 0; pend = 1'b0; rdy = 1'b0;
            m_op = '0; m_a = '0; m_b = '0; cur = '0; nxt = '0;
        end else begin
            v_prev = pend && (ciclo >= t_acc + int'(ESP));
            ciclo  = ciclo + 1;
            if (!pend) begin
                if (rdy && ev) begin
                    pend = 1'b1; t_acc = ciclo; rdy = 1'b0;
                    m_op = cin; m_a = ain; m_b = bin;
                    nxt  = esperado(cin, ain, bin);
                end else begin
                    rdy = 1'b1;
                end
            end else if (v_prev && sl) begin
                pend = 1'b0; cur = nxt; rdy = 1'b1;
                ops  = (ops + 1) % 256;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic comparar();
        logic        e_v;
        logic [18:0] e_o;
        e_v = pend && (ciclo >= t_acc + int'(ESP));
        e_o = e_v ? nxt : cur;
        chk("m_lista",  32'(el),   32'(rdy));
        chk("m_valida", 32'(sv),   32'(e_v));
        chk("m_codigo", 32'(cop),  32'(m_op));
        chk("m_dato0",  32'(d0),   32'(m_a));
        chk("m_dato1",  32'(d1),   32'(m_b));
        chk("m_result", 32'(rout), 32'(e_o[15:0]));
        chk("m_acarreo",32'(acar), 32'(e_o[16]));
        chk("m_cero",   32'(cero), 32'(e_o[17]));
        chk("m_errdiv", 32'(errd), 32'(e_o[18]));
        chk("m_cont",   32'(cnt),  32'(ops));
    endtask

    task automatic emitir(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        ev = 1'b1; cin = op; ain = a; bin = b;
        n = 0;
        while (!el && n < 50) begin @(negedge clk); n++; end
        chk("timeout_lista", 32'(el), 32'd1);
        @(negedge clk);
        ev = 1'b0;
    endtask

    task automatic esperar_salida();
        int n;
        n = 0;
        while (!sv && n < 20) begin @(negedge clk); n++; end
        chk("timeout_valida", 32'(sv), 32'd1);
    endtask

    task automatic op_completa(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] r, input logic c, input logic z, input logic e);
        emitir(op, a, b);
        esperar_salida();
        chk({nm, "_res"}, 32'(rout), 32'(r));
        chk({nm, "_acar"}, 32'(acar), 32'(c));
        chk({nm, "_cero"}, 32'(cero), 32'(z));
        chk({nm, "_err"}, 32'(errd), 32'(e));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ev = 1'b1; cin = 3'd0; ain = 8'd200; bin = 8'd100; sl = 1'b1; force_c = 1'b0;
        rst3_n = 1'b0; ev3 = 1'b0; cin3 = 3'd0; ain3 = 8'd1; bin3 = 8'd2; sl3 = 1'b1;

        fork
            forever begin
                @(negedge clk);
                comparar();
            end
        join_none

        // Reset held with a pending request
        repeat (3) @(negedge clk);
        chk("rst_lista", 32'(el), 32'd0);
        chk("rst_valida", 32'(sv), 32'd0);
        chk("rst_cont", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_lista", 32'(el), 32'd1);
        chk("rel_no_op", 32'(d0), 32'd0);

        op_completa("sum", 3'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b0);
        chk("sum_cont", 32'(cnt), 32'd1);
        op_completa("res0", 3'd1, 8'd5, 8'd5, 16'h0000, 1'b0, 1'b1, 1'b0);
        op_completa("resn", 3'd1, 8'd3, 8'd5, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        force_c = 1'b1;
        op_completa("and", 3'd5, 8'hF0, 8'h0F, 16'h0000, 1'b0, 1'b1, 1'b0);
        force_c = 1'b0;
        op_completa("div0", 3'd3, 8'd7, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        op_completa("mod0", 3'd4, 8'd0, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        op_completa("div", 3'd3, 8'd7, 8'd2, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("div_cont", 32'(cnt), 32'd7);

        // Backpressure with a competing request
        sl = 1'b0;
        emitir(3'd2, 8'd16, 8'd16);
        esperar_salida();
        ev = 1'b1; cin = 3'd5; ain = 8'hAA; bin = 8'h55;
        repeat (5) begin
            @(negedge clk);
            chk("bp_res", 32'(rout), 32'h0100);
            chk("bp_lista", 32'(el), 32'd0);
            chk("bp_dato0", 32'(d0), 32'd16);
        end
        sl = 1'b1;
        op_completa("bp_and", 3'd5, 8'hAA, 8'h55, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("bp_cont", 32'(cnt), 32'd9);

        // Counter wrap after 256 completions
        rst_n = 1'b0;
        @(negedge clk);
        chk("wrap_rst", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            emitir(3'd7, 8'(i), 8'(i * 3));
            esperar_salida();
            if (i == 255) chk("cnt_255", 32'(cnt), 32'd255);
        end
        @(negedge clk);
        chk("cnt_wrap", 32'(cnt), 32'd0);

        // Three-cycle settle: reset mid-operation discards it
        ev3 = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        chk("e3_lista", 32'(el3), 32'd1);
        @(negedge clk);
        ev3 = 1'b0;
        chk("e3_a_val", 32'(sv3), 32'd0);
        chk("e3_a_d0", 32'(d0_3), 32'd1);
        @(negedge clk);
        chk("e3_b_val", 32'(sv3), 32'd0);
        rst3_n = 1'b0;
        @(negedge clk);
        chk("e3_rst_val", 32'(sv3), 32'd0);
        chk("e3_rst_lista", 32'(el3), 32'd0);
        chk("e3_rst_cont", 32'(cnt3), 32'd0);
        chk("e3_rst_d0", 32'(d0_3), 32'd0);
        rst3_n = 1'b1; ev3 = 1'b1;
        @(negedge clk);
        chk("e3_lista2", 32'(el3), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ev3 = 1'b0;
            chk("e3_lat_val", 32'(sv3), 32'd0);
            chk("e3_lat_d0", 32'(d0_3), 32'd1);
            chk("e3_lat_d1", 32'(d1_3), 32'd2);
        end
        @(negedge clk);
        chk("e3_val", 32'(sv3), 32'd1);
        chk("e3_res", 32'(rout3), 32'd3);
        @(negedge clk);
        chk("e3_cont", 32'(cnt3), 32'd1);
        chk("e3_val_off", 32'(sv3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
